// File: rtl/fetch_pc_unit.sv
// Fetch program counter with RUN/HALTED/TRAPPED control and misaligned-branch trapping.
// Optional instr_count output when FETCH_PERF_COUNTER_EN is defined.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [4:0]  imem_index,
    output logic        fetch_valid,
    output logic        trap,
    output logic [31:0] trap_pc
`ifdef FETCH_PERF_COUNTER_EN
    ,
    output logic [31:0] instr_count
`endif
);

    typedef enum logic [1:0] {
        StRun,
        StHalted,
        StTrapped
    } state_t;

    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        r_trap;
    logic        w_trap_next;
    logic [31:0] r_trap_pc;
    logic [31:0] w_trap_pc_next;
    logic        w_misaligned;
    logic        w_advance;

    assign w_misaligned = branch_taken && (branch_target[1:0] != 2'b00);

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_trap_next    = r_trap;
        w_trap_pc_next = r_trap_pc;
        w_advance      = 1'b0;
        unique case (r_state)
            StRun: begin
                if (w_misaligned) begin
                    w_state_next   = StTrapped;
                    w_trap_next    = 1'b1;
                    w_trap_pc_next = branch_target;
                end else begin
                    // halt only changes state; the pc update of this cycle still happens
                    if (halt) begin
                        w_state_next = StHalted;
                    end
                    if (branch_taken) begin
                        w_pc_next = branch_target;
                        w_advance = 1'b1;
                    end else if (!stall) begin
                        w_pc_next = r_pc + 32'd4;
                        w_advance = 1'b1;
                    end
                end
            end
            StHalted: begin
                if (resume && !halt) begin
                    w_state_next = StRun;
                end
            end
            StTrapped: begin
            end
            default: begin
                w_state_next = StRun;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= StRun;
            r_pc      <= ResetPcAligned;
            r_trap    <= 1'b0;
            r_trap_pc <= 32'h0000_0000;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_trap    <= w_trap_next;
            r_trap_pc <= w_trap_pc_next;
        end
    end

`ifdef FETCH_PERF_COUNTER_EN
    logic [31:0] r_instr_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr_count <= 32'h0000_0000;
        end else if (w_advance && (r_instr_count != 32'hFFFF_FFFF)) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign instr_count = r_instr_count;
`else
    logic w_unused_advance;
    assign w_unused_advance = w_advance;
`endif

    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign imem_index  = r_pc[6:2];
    assign fetch_valid = (r_state == StRun) && !stall;
    assign trap        = r_trap;
    assign trap_pc     = r_trap_pc;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: driver queues hand-computed expectations,
// a monitor on the falling edge pops and compares them against the outputs.
module tb_fetch_pc_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  imem_index;
    logic        fetch_valid;
    logic        trap;
    logic [31:0] trap_pc;
`ifdef FETCH_PERF_COUNTER_EN
    logic [31:0] instr_count;
`endif

    fetch_pc_unit #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt         (halt),
        .resume       (resume),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .imem_index   (imem_index),
        .fetch_valid  (fetch_valid),
        .trap         (trap),
        .trap_pc      (trap_pc)
`ifdef FETCH_PERF_COUNTER_EN
        ,
        .instr_count  (instr_count)
`endif
    );

    typedef struct {
        int          row;
        logic [31:0] pc;
        logic        fv;
        logic        trap;
        logic [31:0] trap_pc;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_applied = 0;
    int   n_miscmp  = 0;
    int   row_id    = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input int row, input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        n_applied++;
        if (act !== expv) begin
            n_miscmp++;
            $display("FAIL row %0d %s: got 0x%08h expected 0x%08h", row, name, act, expv);
        end
    endtask

    // Monitor: outputs are presented every cycle, sampled mid-cycle
    initial begin
        exp_t  e;
        logic [31:0] tmp;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.row, "pc", pc, e.pc);
                tmp = e.pc + 32'd4;
                check(e.row, "pc_plus4", pc_plus4, tmp);
                check(e.row, "imem_index", {27'd0, imem_index}, {27'd0, e.pc[6:2]});
                check(e.row, "fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
                check(e.row, "trap", {31'd0, trap}, {31'd0, e.trap});
                check(e.row, "trap_pc", trap_pc, e.trap_pc);
`ifdef FETCH_PERF_COUNTER_EN
                check(e.row, "instr_count", instr_count, e.cnt);
`endif
            end
        end
    end

    // Inputs for the coming edge plus expected outputs for the state left by the last edge
    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t,
                        input logic h, input logic rs, input logic [31:0] epc,
                        input logic efv, input logic etrap, input logic [31:0] etpc,
                        input logic [31:0] ecnt);
        exp_t e;
        @(posedge clock);
        #1;
        reset         = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        halt          = h;
        resume        = rs;
        row_id++;
        e.row     = row_id;
        e.pc      = epc;
        e.fv      = efv;
        e.trap    = etrap;
        e.trap_pc = etpc;
        e.cnt     = ecnt;
        exp_q.push_back(e);
    endtask

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        halt          = 1'b0;
        resume        = 1'b0;
        //   rst  stl  br   target         hlt  res  exp_pc         fv   trp  trap_pc  cnt
        step(1'b1,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0000,1'b1,1'b0,32'h00, 32'd0);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0000,1'b1,1'b0,32'h00, 32'd0);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0004,1'b1,1'b0,32'h00, 32'd1);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0008,1'b1,1'b0,32'h00, 32'd2);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_000C,1'b1,1'b0,32'h00, 32'd3);
        // stall together with aligned branch: branch wins
        step(1'b0,1'b1,1'b1,32'h0000_0040,1'b0,1'b0,32'h0000_0010,1'b0,1'b0,32'h00, 32'd4);
        step(1'b0,1'b1,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0040,1'b0,1'b0,32'h00, 32'd5);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0040,1'b1,1'b0,32'h00, 32'd5);
        // halt with aligned branch, then branches/stall ignored while halted
        step(1'b0,1'b0,1'b1,32'h0000_0080,1'b1,1'b0,32'h0000_0044,1'b1,1'b0,32'h00, 32'd6);
        step(1'b0,1'b0,1'b1,32'h0000_0100,1'b0,1'b0,32'h0000_0080,1'b0,1'b0,32'h00, 32'd7);
        step(1'b0,1'b1,1'b1,32'h0000_0104,1'b0,1'b0,32'h0000_0080,1'b0,1'b0,32'h00, 32'd7);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b1,1'b1,32'h0000_0080,1'b0,1'b0,32'h00, 32'd7);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0080,1'b0,1'b0,32'h00, 32'd7);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b1,32'h0000_0080,1'b0,1'b0,32'h00, 32'd7);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0080,1'b1,1'b0,32'h00, 32'd7);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0084,1'b1,1'b0,32'h00, 32'd8);
        // misaligned branch traps; only reset leaves TRAPPED
        step(1'b0,1'b0,1'b1,32'h0000_0022,1'b0,1'b0,32'h0000_0088,1'b1,1'b0,32'h00, 32'd9);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0088,1'b0,1'b1,32'h22, 32'd9);
        step(1'b0,1'b0,1'b1,32'h0000_0200,1'b0,1'b1,32'h0000_0088,1'b0,1'b1,32'h22, 32'd9);
        step(1'b1,1'b0,1'b1,32'h0000_0033,1'b1,1'b0,32'h0000_0088,1'b0,1'b1,32'h22, 32'd9);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0000,1'b1,1'b0,32'h00, 32'd0);
        // wrap from the top of the address space
        step(1'b0,1'b0,1'b1,32'hFFFF_FFFC,1'b0,1'b0,32'h0000_0004,1'b1,1'b0,32'h00, 32'd1);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'hFFFF_FFFC,1'b1,1'b0,32'h00, 32'd2);
        step(1'b0,1'b1,1'b0,32'h0000_0000,1'b1,1'b0,32'h0000_0000,1'b0,1'b0,32'h00, 32'd3);
        step(1'b0,1'b0,1'b1,32'h0000_0300,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h00, 32'd3);
        // reset from HALTED
        step(1'b1,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h00, 32'd3);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0000,1'b1,1'b0,32'h00, 32'd0);
        // halt with misaligned branch goes to TRAPPED
        step(1'b0,1'b0,1'b1,32'h0000_0041,1'b1,1'b0,32'h0000_0004,1'b1,1'b0,32'h00, 32'd1);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b1,32'h0000_0004,1'b0,1'b1,32'h41, 32'd1);
        step(1'b1,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0004,1'b0,1'b1,32'h41, 32'd1);
        step(1'b0,1'b0,1'b0,32'h0000_0000,1'b0,1'b0,32'h0000_0000,1'b1,1'b0,32'h00, 32'd0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clock);
        end
        n_applied++;
        if (exp_q.size() != 0) begin
            n_miscmp++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
        $finish;
    end

endmodule
